multicycle_control: RTL and testbench

//  Main control FSM of the multicycle MIPS datapath; sits directly upstream of alu_control.

---
 rtl/multicycle_control_if.sv | 30 +++
 rtl/multicycle_control.sv | 112 +++++++++++
 tb/tb_multicycle_control.sv | 124 ++++++++++++
 3 files changed

// File: rtl/multicycle_control_if.sv
// multicycle_control_if: opcode/mem_ready in, datapath control strobes and selects out
interface multicycle_control_if;
  logic [5:0] opcode;
  logic       mem_ready;
  logic       pc_write;
  logic       branch;
  logic       i_or_d;
  logic       mem_write;
  logic       ir_write;
  logic       mem_to_reg;
  logic       reg_dst;
  logic       reg_write;
  logic       alu_src_a;
  logic [1:0] alu_src_b;
  logic [1:0] alu_op;
  logic [1:0] pc_src;
  logic       instr_done;
  logic       illegal_op;
  logic [3:0] state;
  modport master (
    output opcode, mem_ready,
    input  pc_write, branch, i_or_d, mem_write, ir_write, mem_to_reg, reg_dst, reg_write,
           alu_src_a, alu_src_b, alu_op, pc_src, instr_done, illegal_op, state
  );
  modport slave (
    input  opcode, mem_ready,
    output pc_write, branch, i_or_d, mem_write, ir_write, mem_to_reg, reg_dst, reg_write,
           alu_src_a, alu_src_b, alu_op, pc_src, instr_done, illegal_op, state
  );
endinterface

// File: rtl/multicycle_control.sv
// multicycle_control: main FSM of the multicycle MIPS datapath, stalls on mem_ready
module multicycle_control #(
  parameter logic [5:0] OP_RTYPE = 6'h00,
  parameter logic [5:0] OP_LW    = 6'h23,
  parameter logic [5:0] OP_SW    = 6'h2B,
  parameter logic [5:0] OP_BEQ   = 6'h04,
  parameter logic [5:0] OP_ADDI  = 6'h08,
  parameter logic [5:0] OP_J     = 6'h02
) (
  input logic               clk,
  input logic               reset,
  multicycle_control_if.slave bus
);
  typedef enum logic [3:0] {
    FETCH, DECODE, MEMADR, MEMRD, MEMWB, MEMWR, EXECUTE, ALUWB, BRANCH, ADDIEX, ADDIWB, JUMP
  } state_t;
  state_t cur, nxt;
  logic [5:0] op;
  assign op = bus.opcode;
  always_ff @(posedge clk or posedge reset)
    if (reset) cur <= FETCH;
    else cur <= nxt;
  // Outputs are held at zero while reset is high so no write strobe can leak out.
  always_comb begin
    nxt = FETCH;
    bus.pc_write = 1'b0;
    bus.branch = 1'b0;
    bus.i_or_d = 1'b0;
    bus.mem_write = 1'b0;
    bus.ir_write = 1'b0;
    bus.mem_to_reg = 1'b0;
    bus.reg_dst = 1'b0;
    bus.reg_write = 1'b0;
    bus.alu_src_a = 1'b0;
    bus.alu_src_b = 2'b00;
    bus.alu_op = 2'b00;
    bus.pc_src = 2'b00;
    bus.instr_done = 1'b0;
    bus.illegal_op = 1'b0;
    bus.state = reset ? 4'd0 : cur;
    if (!reset)
      case (cur)
        FETCH: begin
          bus.alu_src_b = 2'b01;
          bus.ir_write = bus.mem_ready;
          bus.pc_write = bus.mem_ready;
          nxt = bus.mem_ready ? DECODE : FETCH;
        end
        DECODE: begin
          bus.alu_src_b = 2'b11;
          nxt = (op == OP_LW || op == OP_SW) ? MEMADR :
                op == OP_RTYPE ? EXECUTE :
                op == OP_BEQ   ? BRANCH  :
                op == OP_ADDI  ? ADDIEX  :
                op == OP_J     ? JUMP    : FETCH;
          bus.illegal_op = nxt == FETCH;
        end
        MEMADR: begin
          bus.alu_src_a = 1'b1;
          bus.alu_src_b = 2'b10;
          nxt = op == OP_SW ? MEMWR : MEMRD;
        end
        MEMRD: begin
          bus.i_or_d = 1'b1;
          nxt = bus.mem_ready ? MEMWB : MEMRD;
        end
        MEMWB: begin
          bus.mem_to_reg = 1'b1;
          bus.reg_write = 1'b1;
          bus.instr_done = 1'b1;
        end
        MEMWR: begin
          bus.i_or_d = 1'b1;
          bus.mem_write = 1'b1;
          bus.instr_done = bus.mem_ready;
          nxt = bus.mem_ready ? FETCH : MEMWR;
        end
        EXECUTE: begin
          bus.alu_src_a = 1'b1;
          bus.alu_op = 2'b10;
          nxt = ALUWB;
        end
        ALUWB: begin
          bus.reg_dst = 1'b1;
          bus.reg_write = 1'b1;
          bus.instr_done = 1'b1;
        end
        BRANCH: begin
          bus.alu_src_a = 1'b1;
          bus.alu_op = 2'b01;
          bus.pc_src = 2'b01;
          bus.branch = 1'b1;
          bus.instr_done = 1'b1;
        end
        ADDIEX: begin
          bus.alu_src_a = 1'b1;
          bus.alu_src_b = 2'b10;
          nxt = ADDIWB;
        end
        ADDIWB: begin
          bus.reg_write = 1'b1;
          bus.instr_done = 1'b1;
        end
        JUMP: begin
          bus.pc_src = 2'b10;
          bus.pc_write = 1'b1;
          bus.instr_done = 1'b1;
        end
        default: nxt = FETCH;
      endcase
  end
endmodule

// File: tb/tb_multicycle_control.sv
// tb_multicycle_control: directed per-cycle vectors checked through a scoreboard queue
module tb_multicycle_control;
  logic clk = 1'b0;
  logic reset = 1'b1;
  int tests = 0;
  int failed = 0;
  typedef struct {
    string       name;
    logic [20:0] v;
  } exp_t;
  exp_t q[$];
  multicycle_control_if bus ();
  multicycle_control dut (.clk(clk), .reset(reset), .bus(bus));
  always #5 clk = ~clk;
  // strobes = {pc_write,branch,i_or_d,mem_write,ir_write,mem_to_reg,reg_dst,reg_write,alu_src_a}
  function automatic logic [20:0] v(input logic [8:0] s, input logic [1:0] asb, input logic [1:0] aop,
                                    input logic [1:0] psrc, input logic done, input logic ill,
                                    input logic [3:0] st);
    return {s, asb, aop, psrc, done, ill, st};
  endfunction
  logic [20:0] got;
  assign got = {bus.pc_write, bus.branch, bus.i_or_d, bus.mem_write, bus.ir_write, bus.mem_to_reg,
                bus.reg_dst, bus.reg_write, bus.alu_src_a, bus.alu_src_b, bus.alu_op, bus.pc_src,
                bus.instr_done, bus.illegal_op, bus.state};
  always @(negedge clk)
    if (q.size() > 0) begin
      exp_t e;
      e = q.pop_front();
      tests++;
      if (got !== e.v) begin
        failed++;
        $display("FAIL %s: got %b expected %b", e.name, got, e.v);
      end
    end
  task automatic step(input logic r, input logic [5:0] op, input logic rdy, input string name,
                      input logic [20:0] e);
    exp_t x;
    reset = r;
    bus.opcode = op;
    bus.mem_ready = rdy;
    x.name = name;
    x.v = e;
    q.push_back(x);
    @(posedge clk);
    #1;
  endtask
  logic [20:0] zero, f_r, f_nr, dec, madr, mrd, mwb, mwr_nr, mwr_r, exe, awb, brn, aex, awbi, jmp, ill;
  initial begin
    zero   = '0;
    f_r    = v(9'b100010000, 2'b01, 2'b00, 2'b00, 1'b0, 1'b0, 4'd0);
    f_nr   = v(9'b000000000, 2'b01, 2'b00, 2'b00, 1'b0, 1'b0, 4'd0);
    dec    = v(9'b000000000, 2'b11, 2'b00, 2'b00, 1'b0, 1'b0, 4'd1);
    ill    = v(9'b000000000, 2'b11, 2'b00, 2'b00, 1'b0, 1'b1, 4'd1);
    madr   = v(9'b000000001, 2'b10, 2'b00, 2'b00, 1'b0, 1'b0, 4'd2);
    mrd    = v(9'b001000000, 2'b00, 2'b00, 2'b00, 1'b0, 1'b0, 4'd3);
    mwb    = v(9'b000001010, 2'b00, 2'b00, 2'b00, 1'b1, 1'b0, 4'd4);
    mwr_nr = v(9'b001100000, 2'b00, 2'b00, 2'b00, 1'b0, 1'b0, 4'd5);
    mwr_r  = v(9'b001100000, 2'b00, 2'b00, 2'b00, 1'b1, 1'b0, 4'd5);
    exe    = v(9'b000000001, 2'b00, 2'b10, 2'b00, 1'b0, 1'b0, 4'd6);
    awb    = v(9'b000000110, 2'b00, 2'b00, 2'b00, 1'b1, 1'b0, 4'd7);
    brn    = v(9'b010000001, 2'b00, 2'b01, 2'b01, 1'b1, 1'b0, 4'd8);
    aex    = v(9'b000000001, 2'b10, 2'b00, 2'b00, 1'b0, 1'b0, 4'd9);
    awbi   = v(9'b000000010, 2'b00, 2'b00, 2'b00, 1'b1, 1'b0, 4'd10);
    jmp    = v(9'b100000000, 2'b00, 2'b00, 2'b10, 1'b1, 1'b0, 4'd11);
    bus.opcode = 6'h00;
    bus.mem_ready = 1'b1;
    @(posedge clk);
    #1;
    step(1, 6'h23, 1, "reset_hold", zero);
    step(1, 6'h23, 1, "reset_hold2", zero);
    // LW, no stalls: 5 cycles
    step(0, 6'h23, 1, "lw_fetch", f_r);
    step(0, 6'h23, 1, "lw_decode", dec);
    step(0, 6'h23, 1, "lw_memadr", madr);
    step(0, 6'h23, 1, "lw_memrd", mrd);
    step(0, 6'h23, 1, "lw_memwb", mwb);
    // LW aborted by reset while stalled in MEMRD
    step(0, 6'h23, 1, "lwr_fetch", f_r);
    step(0, 6'h23, 1, "lwr_decode", dec);
    step(0, 6'h23, 1, "lwr_memadr", madr);
    step(0, 6'h23, 0, "lwr_memrd_stall", mrd);
    step(1, 6'h23, 1, "lwr_reset", zero);
    step(1, 6'h23, 1, "lwr_reset2", zero);
    // R-type; opcode garbage outside DECODE must be ignored
    step(0, 6'h00, 1, "r_fetch_after_reset", f_r);
    step(0, 6'h00, 1, "r_decode", dec);
    step(0, 6'h3F, 1, "r_execute", exe);
    step(0, 6'h3F, 1, "r_aluwb", awb);
    // SW with a FETCH stall and three MEMWR stall cycles
    step(0, 6'h2B, 0, "sw_fetch_stall", f_nr);
    step(0, 6'h2B, 1, "sw_fetch", f_r);
    step(0, 6'h2B, 1, "sw_decode", dec);
    step(0, 6'h2B, 1, "sw_memadr", madr);
    step(0, 6'h2B, 0, "sw_memwr_stall1", mwr_nr);
    step(0, 6'h2B, 0, "sw_memwr_stall2", mwr_nr);
    step(0, 6'h2B, 0, "sw_memwr_stall3", mwr_nr);
    step(0, 6'h2B, 1, "sw_memwr_done", mwr_r);
    // BEQ then J
    step(0, 6'h04, 1, "beq_fetch", f_r);
    step(0, 6'h04, 1, "beq_decode", dec);
    step(0, 6'h04, 1, "beq_branch", brn);
    step(0, 6'h02, 1, "j_fetch", f_r);
    step(0, 6'h02, 1, "j_decode", dec);
    step(0, 6'h02, 1, "j_jump", jmp);
    // ADDI
    step(0, 6'h08, 1, "addi_fetch", f_r);
    step(0, 6'h08, 1, "addi_decode", dec);
    step(0, 6'h08, 1, "addi_ex", aex);
    step(0, 6'h08, 1, "addi_wb", awbi);
    // Illegal opcode: 2 cycles then FETCH
    step(0, 6'h3F, 1, "ill_fetch", f_r);
    step(0, 6'h3F, 1, "ill_decode", ill);
    step(0, 6'h3F, 0, "ill_back_to_fetch", f_nr);
    @(negedge clk);
    #1;
    tests++;
    if (q.size() != 0) begin
      failed++;
      $display("FAIL scoreboard_drain: got %0d pending expected 0", q.size());
    end
    $display("[TB] %0d tests run, %0d failed", tests, failed);
    $finish;
  end
endmodule
